// File: rtl/ifu_pkg.sv
// ifu_pkg: shared types and constants for the instruction fetch unit.
//   st_t        : fetch FSM state (EMPTY / RUN / HOLD)
//   IFU_RST_PC  : default first fetch address after reset
package ifu_pkg;

  // EMPTY : nothing in flight is worth presenting (after reset or a jump)
  // RUN   : the instruction is taken live from the bus read data
  // HOLD  : the decoder stalled, so the instruction comes from the hold register
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_RUN   = 2'd1,
    ST_HOLD  = 2'd2
  } st_t;

  localparam logic [15:0] IFU_RST_PC = 16'h0000;

endpackage

// File: rtl/ifu_if.sv
// ifu_if: instruction bus between the fetch unit (master) and the
// instruction memory (slave).
//   ibus_addr : word address, driven by the master, registered there
//   ibus_dout : read data for the address sampled at the previous rising edge
interface ifu_if #(
  parameter int AW = 16,
  parameter int DW = 16
);

  logic [AW-1:0] ibus_addr;
  logic [DW-1:0] ibus_dout;

  modport master (output ibus_addr, input ibus_dout);
  modport slave  (input ibus_addr, output ibus_dout);

endinterface

// File: rtl/ifu_holdbuf.sv
// ifu_holdbuf: one-entry instruction capture used while the decoder stalls,
// plus the mux that chooses between the captured word and live bus data.
//   clk, rst_n : clock, asynchronous active-low reset
//   cap        : capture din into the hold register this cycle
//   clr        : drop the held entry (wins over cap)
//   sel        : present the held word instead of din
//   din        : live bus read data
//   dout       : instruction to the decoder
module ifu_holdbuf #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cap,
  input  logic          clr,
  input  logic          sel,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  logic [DW-1:0] hold_inst_q;
  logic          hold_vld_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_inst_q <= '0;
      hold_vld_q  <= 1'b0;
    end else if (clr) begin
      hold_vld_q  <= 1'b0;
    end else if (cap) begin
      hold_inst_q <= din;
      hold_vld_q  <= 1'b1;
    end
  end

  // A dropped entry never reaches the decoder even if sel is still high.
  assign dout = (sel && hold_vld_q) ? hold_inst_q : din;

endmodule

// File: rtl/ifu.sv
// ifu: instruction fetch unit, initiator side of the instruction bus.
// Drives a registered word address, receives read data one cycle later and
// hands each instruction to the decoder with its PC and a valid flag.
// Handles sequential fetch, decoder stall and jump redirects.
//   clk, rst_n       : clock (shared with the bus), async active-low reset
//   ibus             : instruction bus, master side (ibus_addr / ibus_dout)
//   stall            : decoder cannot take the current instruction
//   jmp_en, jmp_addr : redirect fetch to jmp_addr (priority over stall)
//   inst, inst_pc    : instruction to the decoder and its word address
//   inst_vld         : inst / inst_pc are meaningful
//   perf_fetch       : (IFU_PERF_EN) cycles with inst_vld & ~stall & ~jmp_en
//   perf_bubble      : (IFU_PERF_EN) cycles with inst_vld == 0
//   st_dbg_o         : current FSM state, for observation
// Optional feature macro: IFU_PERF_EN adds the two 32-bit counters.
//
// Handshake: an instruction is consumed by the decoder in any cycle where
// inst_vld=1, stall=0 and jmp_en=0; otherwise it stays on inst/inst_pc.
module ifu
  import ifu_pkg::*;
#(
  parameter int            DW     = 16,
  parameter int            AW     = 16,
  parameter logic [AW-1:0] RST_PC = AW'(IFU_RST_PC)
) (
  input  logic          clk,
  input  logic          rst_n,
  ifu_if.master         ibus,
  input  logic          stall,
  input  logic          jmp_en,
  input  logic [AW-1:0] jmp_addr,
  output logic [DW-1:0] inst,
  output logic [AW-1:0] inst_pc,
  output logic          inst_vld,
`ifdef IFU_PERF_EN
  output logic [31:0]   perf_fetch,
  output logic [31:0]   perf_bubble,
`endif
  output st_t           st_dbg_o
);

  logic [AW-1:0] fa_q;       // fetch address on the bus
  logic [AW-1:0] pend_pc_q;  // address whose data is on ibus_dout
  st_t           st_q;
  logic          vld_q;

  logic hb_cap;
  logic hb_clr;
  logic hb_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fa_q      <= RST_PC;
      pend_pc_q <= '0;
      st_q      <= ST_EMPTY;
      vld_q     <= 1'b0;
    end else if (jmp_en) begin
      // The fetch already in flight belongs to the old stream: discard it.
      fa_q  <= jmp_addr;
      st_q  <= ST_EMPTY;
      vld_q <= 1'b0;
    end else begin
      case (st_q)
        ST_RUN: begin
          if (stall) begin
            // The bus keeps re-reading fa (one ahead), so the current word
            // must be captured; fa and pend_pc stay put.
            st_q <= ST_HOLD;
          end else begin
            pend_pc_q <= fa_q;
            fa_q      <= fa_q + AW'(1);
          end
        end
        ST_HOLD: begin
          if (!stall) begin
            // Held word consumed; ibus_dout already carries mem[fa].
            pend_pc_q <= fa_q;
            fa_q      <= fa_q + AW'(1);
            st_q      <= ST_RUN;
          end
        end
        default: begin
          // Nothing valid to stall on, so fetch always proceeds.
          pend_pc_q <= fa_q;
          fa_q      <= fa_q + AW'(1);
          st_q      <= ST_RUN;
          vld_q     <= 1'b1;
        end
      endcase
    end
  end

  assign hb_cap = !jmp_en && stall && (st_q == ST_RUN);
  assign hb_clr = jmp_en || ((st_q == ST_HOLD) && !stall);
  assign hb_sel = (st_q == ST_HOLD);

  ifu_holdbuf #(.DW(DW)) u_holdbuf (
    .clk   (clk),
    .rst_n (rst_n),
    .cap   (hb_cap),
    .clr   (hb_clr),
    .sel   (hb_sel),
    .din   (ibus.ibus_dout),
    .dout  (inst)
  );

  assign ibus.ibus_addr = fa_q;
  assign inst_pc        = pend_pc_q;
  assign inst_vld       = vld_q;
  assign st_dbg_o       = st_q;

`ifdef IFU_PERF_EN
  logic [31:0] perf_fetch_q;
  logic [31:0] perf_bubble_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_q  <= '0;
      perf_bubble_q <= '0;
    end else begin
      perf_fetch_q  <= perf_fetch_q  + 32'(inst_vld && !stall && !jmp_en);
      perf_bubble_q <= perf_bubble_q + 32'(!inst_vld);
    end
  end

  assign perf_fetch  = perf_fetch_q;
  assign perf_bubble = perf_bubble_q;
`endif

endmodule

// File: doc/ifu.md
# ifu

Instruction fetch unit: the initiator side of the instruction bus. Drives the `ibus` word address, accepts the read data one cycle later, and presents each instruction with its PC and a valid flag to the decoder. Sits between `ibus` and the decode stage. Handles sequential fetch, decoder back-pressure (stall) and jump redirects.

## Interface
- `DW`, 16, instruction width; must equal `ibus` `DW`
- `AW`, 16, word-address width; must equal `ibus` `AW`
- `RST_PC`, 0, first fetch address after reset

- `clk` in 1: the single clock, shared with `ibus`.
- `rst_n` in 1: asynchronous, active-low reset.
- `ibus_addr` out AW: fetch address to `ibus.addr`; registered.
- `ibus_dout` in DW: `ibus.dout`; data for the address sampled at the previous `clk` rising edge.
- `stall` in 1: decoder cannot accept the current instruction.
- `jmp_en` in 1: redirect fetch this cycle.
- `jmp_addr` in AW: redirect target.
- `inst` out DW: instruction to the decoder.
- `inst_pc` out AW: word address of `inst`.
- `inst_vld` out 1: `inst`/`inst_pc` are meaningful.

## Operation
- Registers:
  - `fa`: fetch address, drives `ibus_addr`.
  - `pend_pc`/`pend_vld`: the address whose data is on `ibus_dout` this cycle.
  - `hold_inst`/`hold_vld`: the stall capture.
- FSM `st`:
  - EMPTY: `pend_vld=0`.
  - RUN: data taken live from `ibus_dout`.
  - HOLD: data taken from `hold_inst`.
- Outputs:
  - `inst` = HOLD ? `hold_inst` : `ibus_dout`.
  - `inst_pc` = `pend_pc`.
  - `inst_vld` = `st`≠EMPTY.
- Advance (`~stall`, `~jmp_en`):
  - `pend_pc<=fa`, `fa<=fa+1`, `st<=RUN`.
  - In HOLD, the hold entry is released; the next instruction comes live from `ibus`.
- Stall in RUN:
  - `hold_inst<=ibus_dout`, `st<=HOLD`.
  - `fa` and `pend_pc` frozen.
  - The capture is mandatory because `ibus` keeps re-reading `fa`, which is one ahead of `pend_pc`.
- Stall in HOLD: everything frozen. Stall in EMPTY: no effect; fetch continues.
- Jump has priority over stall and advance:
  - `fa<=jmp_addr`, `st<=EMPTY`, `hold_vld<=0`.
  - The in-flight fetch is discarded.
  - Outputs in the `jmp_en` cycle itself are unchanged.
- Address arithmetic: modulo 2^AW. `fa=2^AW-1` advances to 0 with no flag.
- Reset (any time, including mid-stall or mid-jump):
  - `fa=RST_PC`, `pend_pc=0`, `st=EMPTY`, `hold_inst=0`.
  - Outputs reset to `ibus_addr=RST_PC`, `inst_pc=0`, `inst_vld=0`. `inst` follows `ibus_dout` (not HOLD).

## Timing
- `ibus` read latency is exactly 1 cycle; the `ibus` read itself adds none.
- Reset release: first edge with `rst_n=1` launches `RST_PC`. The next cycle shows `inst_vld=1`, `inst_pc=RST_PC`.
- Steady state: one instruction per cycle, consecutive `inst_pc` values.
- Jump:
  - `jmp_en` in cycle N gives `inst_vld=0` in N+1.
  - In N+2, `inst_pc=jmp_addr` with mem[`jmp_addr`].
  - Bubble cost is exactly 1 cycle.
- Stall release: the instruction that was on `inst` is consumed in the release cycle. The next cycle shows `pend_pc+1`; no bubble.

## Configuration
- `IFU_PERF_EN` defined: adds two outputs, both reset to 0 and wrapping silently.
  - `perf_fetch` (out 32): count of cycles with `inst_vld & ~stall & ~jmp_en`.
  - `perf_bubble` (out 32): count of cycles with `inst_vld=0`.
- Undefined: these ports and their counters do not exist. Fetch behaviour is identical either way.

## Structure
- Shared package `ifu_pkg`: the `st` enum (EMPTY/RUN/HOLD) and the `RST_PC` default constant.
- One sub-module, `ifu_holdbuf`: the hold register plus the output mux, with ports `clk`, `rst_n`, `cap`, `clr`, `sel`, `din`, `dout`.
- PC/FSM logic stays in `ifu`.

## Test plan
Bench instantiates `ibus` (`RAM_AW=7`) preloaded with mem[a]=16'h1000+a. `RST_PC=0` unless stated.
- Reset then free-run 6 cycles: `inst_vld` 0 for one cycle, then `inst_pc` 0..4 with `inst` 16'h1000..16'h1004.
- Stall for 3 cycles while `inst_pc=2`: `inst` holds 16'h1002 and `ibus_addr` holds 3. After release, `inst_pc=3`, `inst=16'h1003`, no bubble.
- `jmp_en` with `jmp_addr=16'h0040` during RUN: one cycle `inst_vld=0`, then `inst_pc=16'h40`, `inst=16'h1040`, then `16'h41`.
- `jmp_en` and `stall` both high while in HOLD: hold dropped, one bubble, then `inst_pc=jmp_addr`.
- Assert `rst_n=0` mid-stall: `inst_vld` drops immediately, `ibus_addr=0`. After release, fetch restarts at 0.
- `RST_PC=16'hFFFE`: `inst_pc` sequence FFFE, FFFF, 0000, 0001.
- With `IFU_PERF_EN`, over the 6-cycle free run of the first scenario with no stall or jump: `perf_fetch=5`, `perf_bubble=1`.
